// File: rtl/calculator_keypad_ctrl.sv
// Cursor-driven calculator keypad: edge-detects five buttons, walks a
// 6x4 key grid and assembles operands, operator and an exec pulse.
module calculator_keypad_ctrl #(
  parameter int MAX_DIGITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode,
  input  logic        btn_u,
  input  logic        btn_d,
  input  logic        btn_l,
  input  logic        btn_r,
  input  logic        btn_c,
  output logic [2:0]  pos_x,
  output logic [1:0]  pos_y,
  output logic [2:0]  op,
  output logic [15:0] op1,
  output logic [15:0] op2,
  output logic [15:0] input_screen,
  output logic [1:0]  calc_state,
  output logic        exec
);

  localparam logic [1:0] ST_OP1  = 2'd0;
  localparam logic [1:0] ST_OP2  = 2'd1;
  localparam logic [1:0] ST_SHOW = 2'd2;

  logic [4:0]  prev_q, prev_d;
  logic [2:0]  pos_x_q, pos_x_d;
  logic [1:0]  pos_y_q, pos_y_d;
  logic [2:0]  op_q, op_d;
  logic [15:0] op1_q, op1_d;
  logic [15:0] op2_q, op2_d;
  logic [15:0] scr_q, scr_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [1:0]  st_q, st_d;
  logic        exec_q, exec_d;

  logic [4:0] btn, rise;
  logic       sel_c, sel_u, sel_d, sel_l, sel_r;
  logic [4:0] key_idx;
  logic [3:0] digit;
  logic       is_digit, is_clr, is_bs, is_op, is_exe, digit_ok;

  assign btn   = {btn_c, btn_u, btn_d, btn_l, btn_r};
  assign rise  = btn & ~prev_q;
  // one-hot action select, select wins over all moves
  assign sel_c = rise[4];
  assign sel_u = rise[3] & ~rise[4];
  assign sel_d = rise[2] & ~|rise[4:3];
  assign sel_l = rise[1] & ~|rise[4:2];
  assign sel_r = rise[0] & ~|rise[4:1];

  assign key_idx  = 5'(pos_y_q) * 5'd6 + 5'(pos_x_q);
  assign digit    = key_idx[3:0];
  assign is_digit = (pos_y_q != 2'd3) && (key_idx < 5'd16);
  assign is_clr   = (pos_y_q == 2'd2) && (pos_x_q == 3'd4);
  assign is_bs    = (pos_y_q == 2'd2) && (pos_x_q == 3'd5);
  assign is_op    = (pos_y_q == 2'd3) && (pos_x_q < 3'd5);
  assign is_exe   = (pos_y_q == 2'd3) && (pos_x_q == 3'd5);
  assign digit_ok = mode || (digit <= 4'd9);

  always_comb begin
    prev_d  = btn;
    pos_x_d = pos_x_q;
    pos_y_d = pos_y_q;
    op_d    = op_q;
    op1_d   = op1_q;
    op2_d   = op2_q;
    scr_d   = scr_q;
    cnt_d   = cnt_q;
    st_d    = st_q;
    exec_d  = 1'b0;
    unique case (1'b1)
      sel_c: begin
        if (is_clr) begin
          scr_d = '0;
          op1_d = '0;
          op2_d = '0;
          op_d  = '0;
          cnt_d = '0;
          st_d  = ST_OP1;
        end else if (is_bs) begin
          if (st_q != ST_SHOW && cnt_q != 3'd0) begin
            scr_d = scr_q >> 4;
            cnt_d = cnt_q - 3'd1;
          end
        end else if (is_exe) begin
          if (st_q == ST_OP2) begin
            op2_d  = scr_q;
            exec_d = 1'b1;
            st_d   = ST_SHOW;
          end
        end else if (is_op) begin
          op_d = pos_x_q;
          if (st_q != ST_OP2) begin
            // in SHOW op1 is kept as the chained result slot
            if (st_q == ST_OP1) op1_d = scr_q;
            scr_d = '0;
            cnt_d = '0;
            st_d  = ST_OP2;
          end
        end else if (is_digit && digit_ok) begin
          if (st_q == ST_SHOW) begin
            op1_d = '0;
            op2_d = '0;
            scr_d = {12'h000, digit};
            cnt_d = 3'd1;
            st_d  = ST_OP1;
          end else if (cnt_q != 3'(MAX_DIGITS)) begin
            scr_d = {scr_q[11:0], digit};
            cnt_d = cnt_q + 3'd1;
          end
        end
      end
      sel_u: pos_y_d = pos_y_q - 2'd1;
      sel_d: pos_y_d = pos_y_q + 2'd1;
      sel_l: pos_x_d = (pos_x_q == 3'd0) ? 3'd5 : pos_x_q - 3'd1;
      sel_r: pos_x_d = (pos_x_q == 3'd5) ? 3'd0 : pos_x_q + 3'd1;
      default: ;
    endcase
  end

  // prev levels reset high so a button held through reset is ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q  <= '1;
      pos_x_q <= '0;
      pos_y_q <= '0;
      op_q    <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      scr_q   <= '0;
      cnt_q   <= '0;
      st_q    <= ST_OP1;
      exec_q  <= 1'b0;
    end else begin
      prev_q  <= prev_d;
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      op_q    <= op_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      scr_q   <= scr_d;
      cnt_q   <= cnt_d;
      st_q    <= st_d;
      exec_q  <= exec_d;
    end
  end

  assign pos_x        = pos_x_q;
  assign pos_y        = pos_y_q;
  assign op           = op_q;
  assign op1          = op1_q;
  assign op2          = op2_q;
  assign input_screen = scr_q;
  assign calc_state   = st_q;
  assign exec         = exec_q;

endmodule

// File: tb/tb_calculator_keypad_ctrl.sv
// Directed bench for calculator_keypad_ctrl: cursor moves, digit
// entry, operator/exec flow, priority and reset behaviour.
module tb_calculator_keypad_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        mode;
  logic [4:0]  btns;
  logic [2:0]  pos_x;
  logic [1:0]  pos_y;
  logic [2:0]  op;
  logic [15:0] op1, op2, input_screen;
  logic [1:0]  calc_state;
  logic        exec;

  int n_run = 0;
  int n_fail = 0;
  int exec_cnt = 0;
  int cx = 0;
  int cy = 0;

  always #5 clk = ~clk;

  always @(posedge clk) if (exec) exec_cnt++;

  calculator_keypad_ctrl #(.MAX_DIGITS(4)) dut (
    .clk(clk), .rst(rst), .mode(mode),
    .btn_u(btns[0]), .btn_d(btns[1]), .btn_l(btns[2]),
    .btn_r(btns[3]), .btn_c(btns[4]),
    .pos_x(pos_x), .pos_y(pos_y), .op(op),
    .op1(op1), .op2(op2), .input_screen(input_screen),
    .calc_state(calc_state), .exec(exec)
  );

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(int b);
    @(negedge clk); btns[b] = 1'b1;
    @(negedge clk); btns[b] = 1'b0;
    @(negedge clk);
  endtask

  task automatic move_to(int tx, int ty);
    int n;
    n = (tx - cx + 6) % 6;
    for (int i = 0; i < n; i++) press(3);
    n = (ty - cy + 4) % 4;
    for (int i = 0; i < n; i++) press(1);
    cx = tx;
    cy = ty;
  endtask

  task automatic sel(int tx, int ty);
    move_to(tx, ty);
    press(4);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    cx = 0;
    cy = 0;
  endtask

  initial begin
    rst  = 1'b1;
    mode = 1'b1;
    btns = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    chk("rst_pos_x", 32'(pos_x), 0);
    chk("rst_pos_y", 32'(pos_y), 0);
    chk("rst_op", 32'(op), 0);
    chk("rst_op1", 32'(op1), 0);
    chk("rst_op2", 32'(op2), 0);
    chk("rst_screen", 32'(input_screen), 0);
    chk("rst_state", 32'(calc_state), 0);
    chk("rst_exec", 32'(exec), 0);

    for (int i = 1; i <= 6; i++) begin
      press(3);
      chk($sformatf("right_%0d", i), 32'(pos_x), 32'(i % 6));
    end
    press(0);
    chk("up_wrap", 32'(pos_y), 3);
    press(1);
    chk("down_wrap", 32'(pos_y), 0);
    press(2);
    chk("left_wrap", 32'(pos_x), 5);
    press(3);
    chk("right_back", 32'(pos_x), 0);

    do_reset();
    mode = 1'b1;
    sel(1, 0); chk("hex_d1", 32'(input_screen), 32'h0001);
    sel(4, 1); chk("hex_d2", 32'(input_screen), 32'h001A);
    sel(3, 0); chk("hex_d3", 32'(input_screen), 32'h01A3);
    sel(3, 2); chk("hex_d4", 32'(input_screen), 32'h1A3F);
    sel(2, 0); chk("hex_full", 32'(input_screen), 32'h1A3F);
    sel(5, 2); chk("bs", 32'(input_screen), 32'h01A3);
    sel(2, 0); chk("after_bs", 32'(input_screen), 32'h1A32);
    mode = 1'b0;
    @(negedge clk);
    chk("mode_keep", 32'(input_screen), 32'h1A32);
    sel(4, 2); chk("clr", 32'(input_screen), 0);
    sel(4, 1); chk("dec_rej_A", 32'(input_screen), 0);
    sel(3, 1); chk("dec_9", 32'(input_screen), 32'h0009);

    do_reset();
    mode = 1'b0;
    exec_cnt = 0;
    sel(1, 0);
    sel(2, 0);
    chk("ent_12", 32'(input_screen), 32'h0012);
    sel(0, 3);
    chk("add_op1", 32'(op1), 32'h0012);
    chk("add_op", 32'(op), 0);
    chk("add_state", 32'(calc_state), 1);
    chk("add_clr_scr", 32'(input_screen), 0);
    sel(5, 2);
    chk("bs_empty", 32'(input_screen), 0);
    sel(3, 0);
    sel(4, 0);
    chk("ent_34", 32'(input_screen), 32'h0034);
    sel(5, 3);
    chk("exe_op2", 32'(op2), 32'h0034);
    chk("exe_op1", 32'(op1), 32'h0012);
    chk("exe_op", 32'(op), 0);
    chk("exe_state", 32'(calc_state), 2);
    chk("exe_pulses", 32'(exec_cnt), 1);
    press(4);
    chk("exe_show_ign", 32'(exec_cnt), 1);
    chk("exe_show_st", 32'(calc_state), 2);
    sel(3, 3);
    chk("chain_op", 32'(op), 3);
    chk("chain_op1", 32'(op1), 32'h0012);
    chk("chain_state", 32'(calc_state), 1);
    chk("chain_scr", 32'(input_screen), 0);
    sel(4, 3);
    chk("repl_op", 32'(op), 4);
    chk("repl_op1", 32'(op1), 32'h0012);
    sel(5, 3);
    chk("exe2_pulses", 32'(exec_cnt), 2);
    sel(5, 0);
    chk("show_dig_scr", 32'(input_screen), 32'h0005);
    chk("show_dig_op1", 32'(op1), 0);
    chk("show_dig_op2", 32'(op2), 0);
    chk("show_dig_st", 32'(calc_state), 0);
    sel(5, 3);
    chk("exe_op1_ign", 32'(exec_cnt), 2);
    chk("exe_op1_st", 32'(calc_state), 0);
    sel(2, 3);
    chk("sub_op", 32'(op), 2);
    sel(4, 2);
    chk("clr_state", 32'(calc_state), 0);
    chk("clr_op", 32'(op), 0);
    chk("clr_op1", 32'(op1), 0);

    move_to(1, 0);
    @(negedge clk); btns[4] = 1'b1; btns[3] = 1'b1;
    @(negedge clk); btns = '0;
    @(negedge clk);
    chk("prio_scr", 32'(input_screen), 32'h0001);
    chk("prio_pos_x", 32'(pos_x), 1);

    sel(1, 0);
    @(negedge clk); rst = 1'b1;
    #1 chk("async_rst_scr", 32'(input_screen), 0);
    @(negedge clk); rst = 1'b0;
    cx = 0; cy = 0;
    chk("abort_exec", 32'(exec_cnt), 2);

    move_to(1, 0);
    @(negedge clk); btns[4] = 1'b1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    cx = 0; cy = 0;
    repeat (2) @(negedge clk);
    btns[4] = 1'b0;
    @(negedge clk);
    chk("held_c_scr", 32'(input_screen), 0);
    @(negedge clk); btns[3] = 1'b1; rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
    btns[3] = 1'b0;
    @(negedge clk);
    chk("held_r_pos", 32'(pos_x), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
